// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and read-port slice helper for the register file
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Bit offset of a port's field inside a flat, port-packed bus.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with release/reserve/flush and live busy count
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rel0,
  input  logic [ADDR_W-1:0]      rel0_addr,
  input  logic                   rel1,
  input  logic [ADDR_W-1:0]      rel1_addr,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic                   flush,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE = 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d, n_set, n_clr;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (rel0) busy_d[rel0_addr] = 1'b0;
      if (rel1) busy_d[rel1_addr] = 1'b0;
      // Reserve is applied last: a new producer outranks the retiring one.
      if (rsv_en) busy_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;

    n_set = '0;
    n_clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && busy_d[i]) n_set = n_set + ONE;
      if (busy_q[i] && !busy_d[i]) n_clr = n_clr + ONE;
    end
    cnt_d = flush ? '0 : (cnt_q + n_set - n_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write-first bypass and busy scoreboard
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr0_rel,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     wr1_rel,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr0_ok, wr1_ok, rel0, rel1;

  assign wr0_ok = wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
  assign wr1_ok = wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);
  assign rel0   = wr0_en && wr0_rel;
  assign rel1   = wr1_en && wr1_rel;

  // wr1 is the younger instruction, so its write lands after wr0's.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr0_ok) mem[wr0_addr] <= wr0_data;
      if (wr1_ok) mem[wr1_addr] <= wr1_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .rel0      (rel0),
    .rel0_addr (wr0_addr),
    .rel1      (rel1),
    .rel1_addr (wr1_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              rel_hit;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a       = rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];
      rel_hit = (rel0 && wr0_addr == a) || (rel1 && wr1_addr == a);
      if (reset || (ZERO_REG != 0 && a == '0)) begin
        rd_data[port_lsb(k, DATA_W) +: DATA_W] = '0;
        rd_busy[k] = 1'b0;
      end else begin
        if (wr1_en && wr1_addr == a)
          rd_data[port_lsb(k, DATA_W) +: DATA_W] = wr1_data;
        else if (wr0_en && wr0_addr == a)
          rd_data[port_lsb(k, DATA_W) +: DATA_W] = wr0_data;
        else
          rd_data[port_lsb(k, DATA_W) +: DATA_W] = mem[a];
        // Hide a busy bit being released this cycle so it agrees with the bypassed data.
        rd_busy[k] = busy[a] && !rel_hit;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard-driven bench for reg_file_mp
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  localparam int S_CNT = 6;
  localparam int S_ZD0 = 7;
  localparam int S_ZCNT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data_z;
  logic [NR-1:0]    rd_busy, rd_busy_z;
  logic          wr0_en, wr0_rel, wr1_en, wr1_rel, rsv_en, flush;
  logic [AW-1:0] wr0_addr, wr1_addr, rsv_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic [AW:0]   busy_cnt, busy_cnt_z;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_rel(wr0_rel),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_rel(wr1_rel),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_rel(wr0_rel),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_rel(wr1_rel),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(busy_cnt_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      0, 1, 2:  v = rd_data[sel*DW +: DW];
      3, 4, 5:  v = {31'd0, rd_busy[sel-3]};
      S_CNT:    v = {26'd0, busy_cnt};
      S_ZD0:    v = rd_data_z[DW-1:0];
      S_ZCNT:   v = {26'd0, busy_cnt_z};
      default:  v = 'x;
    endcase
    return v;
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    #1;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk(x.tag, observe(x.sel), x.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic idle();
    wr0_en = 0; wr0_rel = 0; wr1_en = 0; wr1_rel = 0; rsv_en = 0; flush = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_data = '0; rsv_addr = '0;
    set_rd(5'd1, 5'd2, 5'd3);
    #2;
    for (int k = 0; k < NR; k++) begin
      expect_val($sformatf("rst_data%0d", k), k, 32'h0);
      expect_val($sformatf("rst_busy%0d", k), 3 + k, 32'h0);
    end
    expect_val("rst_cnt", S_CNT, 32'h0);
    expect_val("rst_cnt_z", S_ZCNT, 32'h0);
    drain();
    @(negedge clk);
    reset = 1'b0;

    // r5 write, then asynchronous reset wipes it with no edge
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'h1234;
    step();
    idle();
    set_rd(5'd5, 5'd5, 5'd5);
    expect_val("r5_stored", 0, 32'h1234);
    drain();
    reset = 1'b1;
    expect_val("r5_async_rst", 0, 32'h0);
    expect_val("r5_async_rst_z", S_ZD0, 32'h0);
    drain();
    reset = 1'b0;
    @(negedge clk);

    // dual write to r3: wr1 wins in bypass and storage
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'hAAAA;
    wr1_en = 1; wr1_addr = 5'd3; wr1_data = 32'h5555;
    set_rd(5'd3, 5'd3, 5'd3);
    for (int k = 0; k < NR; k++) expect_val($sformatf("r3_bypass%0d", k), k, 32'h5555);
    drain();
    step();
    idle();
    for (int k = 0; k < NR; k++) expect_val($sformatf("r3_stored%0d", k), k, 32'h5555);
    drain();

    // reserve r7, then release via wr0 with bypass
    rsv_en = 1; rsv_addr = 5'd7;
    step();
    idle();
    set_rd(5'd7, 5'd3, 5'd3);
    expect_val("r7_busy", 3, 32'h1);
    expect_val("r7_cnt", S_CNT, 32'h1);
    drain();
    wr0_en = 1; wr0_rel = 1; wr0_addr = 5'd7; wr0_data = 32'h42;
    expect_val("r7_wb_data", 0, 32'h42);
    expect_val("r7_wb_busy", 3, 32'h0);
    drain();
    step();
    idle();
    expect_val("r7_rel_cnt", S_CNT, 32'h0);
    expect_val("r7_rel_busy", 3, 32'h0);
    drain();

    // r9: reserve beats same-cycle release
    rsv_en = 1; rsv_addr = 5'd9;
    step();
    idle();
    expect_val("r9_pre_cnt", S_CNT, 32'h1);
    drain();
    rsv_en = 1; rsv_addr = 5'd9;
    wr1_en = 1; wr1_rel = 1; wr1_addr = 5'd9; wr1_data = 32'h99;
    step();
    idle();
    set_rd(5'd9, 5'd3, 5'd3);
    expect_val("r9_busy", 3, 32'h1);
    expect_val("r9_cnt", S_CNT, 32'h1);
    expect_val("r9_data", 0, 32'h99);
    drain();

    // clear scoreboard on both instances
    flush = 1;
    step();
    idle();
    expect_val("flush_cnt", S_CNT, 32'h0);
    expect_val("flush_cnt_z", S_ZCNT, 32'h0);
    drain();

    // register 0 behaviour for both ZERO_REG settings
    wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'hFFFF;
    rsv_en = 1; rsv_addr = 5'd0;
    set_rd(5'd0, 5'd0, 5'd0);
    expect_val("r0_bypass", 0, 32'h0);
    expect_val("r0_bypass_z", S_ZD0, 32'hFFFF);
    drain();
    step();
    idle();
    expect_val("r0_data", 0, 32'h0);
    expect_val("r0_busy", 3, 32'h0);
    expect_val("r0_cnt", S_CNT, 32'h0);
    expect_val("r0_data_z", S_ZD0, 32'hFFFF);
    expect_val("r0_cnt_z", S_ZCNT, 32'h1);
    drain();

    // reserve r1..r4, re-reserve, dual release, then flush with reserve
    for (int r = 1; r <= 4; r++) begin
      rsv_en = 1; rsv_addr = AW'(r);
      step();
      idle();
      expect_val($sformatf("fill_cnt%0d", r), S_CNT, 32'(r));
      drain();
    end
    rsv_en = 1; rsv_addr = 5'd4;
    step();
    idle();
    expect_val("rersv_cnt", S_CNT, 32'd4);
    drain();
    wr0_en = 1; wr0_rel = 1; wr0_addr = 5'd1; wr0_data = 32'h11;
    wr1_en = 1; wr1_rel = 1; wr1_addr = 5'd2; wr1_data = 32'h22;
    step();
    idle();
    set_rd(5'd1, 5'd2, 5'd3);
    expect_val("dual_rel_cnt", S_CNT, 32'd2);
    expect_val("dual_rel_b1", 3, 32'h0);
    expect_val("dual_rel_b3", 5, 32'h1);
    drain();
    flush = 1; rsv_en = 1; rsv_addr = 5'd6;
    step();
    idle();
    set_rd(5'd3, 5'd4, 5'd6);
    expect_val("fl_cnt", S_CNT, 32'h0);
    for (int k = 0; k < NR; k++) expect_val($sformatf("fl_busy%0d", k), 3 + k, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
